// File: rtl/ina220_word_assembler_if.sv
// Byte-stream input and word-stream output of the INA220 word assembler.
// The slave modport is the assembler; the master modport is its environment
// (I2C control FSM on the byte side, host logic on the word side).
`timescale 1ns/1ps
interface ina220_word_assembler_if;
  logic        WE;
  logic [7:0]  INA220_DATA;
  logic [2:0]  REG_TAG;
  logic        FRAME_CLR;
  logic [15:0] RESULT;
  logic [2:0]  RESULT_TAG;
  logic        RESULT_VALID;
  logic        RESULT_READY;
  logic [4:0]  LEVEL;
  logic        ERR_TIMEOUT;
  logic        ERR_OVF;
  logic        ERR_CLR;

  modport master (
    output WE, INA220_DATA, REG_TAG, FRAME_CLR, RESULT_READY, ERR_CLR,
    input  RESULT, RESULT_TAG, RESULT_VALID, LEVEL, ERR_TIMEOUT, ERR_OVF
  );

  modport slave (
    input  WE, INA220_DATA, REG_TAG, FRAME_CLR, RESULT_READY, ERR_CLR,
    output RESULT, RESULT_TAG, RESULT_VALID, LEVEL, ERR_TIMEOUT, ERR_OVF
  );
endinterface

// File: rtl/ina220_word_assembler.sv
// INA220 word assembler: pairs MSB/LSB bytes from the I2C control FSM into
// tagged 16-bit register words and buffers them in a small FIFO with a
// valid/ready readout. Sticky flags flag abandoned pairs and dropped words.
`timescale 1ns/1ps
module ina220_word_assembler #(
  parameter int unsigned DEPTH          = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input logic                    PCLK,
  input logic                    PRESETN,
  ina220_word_assembler_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_LVL = 5'(DEPTH);
  localparam logic [15:0] TMO_LAST  = TIMEOUT_CYCLES - 16'd1;

  typedef enum logic {
    WAIT_MSB,
    WAIT_LSB
  } byte_state_t;

  // Strobe edge detection
  logic        we_q;
  logic        byte_evt;

  // Byte FSM and pair assembly
  byte_state_t state_q, state_d;
  logic        capture_msb;
  logic        emit_word;
  logic        timeout_hit;
  logic        timer_run;
  logic [15:0] timer_q;
  logic [7:0]  msb_q;
  logic [2:0]  tag_q;

  // Staged word, pushed one cycle after the LSB event
  logic        push_q;
  logic [15:0] push_word_q;
  logic [2:0]  push_tag_q;

  // FIFO
  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_inc;
  logic [4:0]    level_q, level_d;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          drop_word;
  logic [15:0]   head_word_q, head_word_d;
  logic [2:0]    head_tag_q, head_tag_d;

  // Sticky errors
  logic          err_tmo_q;
  logic          err_ovf_q;

  assign byte_evt = ~bus.WE & we_q;

  // Register the strobe so a long low pulse produces a single event
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) we_q <= 1'b1;
    else          we_q <= bus.WE;
  end

  // Byte FSM state register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state_q <= WAIT_MSB;
    else          state_q <= state_d;
  end

  // Byte FSM next state; FRAME_CLR overrides any coincident byte event
  always_comb begin
    state_d     = state_q;
    capture_msb = 1'b0;
    emit_word   = 1'b0;
    timeout_hit = 1'b0;
    timer_run   = 1'b0;
    if (bus.FRAME_CLR) begin
      state_d = WAIT_MSB;
    end else begin
      unique case (state_q)
        WAIT_MSB: begin
          if (byte_evt) begin
            capture_msb = 1'b1;
            state_d     = WAIT_LSB;
          end
        end
        WAIT_LSB: begin
          // An LSB arriving on the terminal count still completes the word
          if (byte_evt) begin
            emit_word = 1'b1;
            state_d   = WAIT_MSB;
          end else if (timer_q == TMO_LAST) begin
            timeout_hit = 1'b1;
            state_d     = WAIT_MSB;
          end else begin
            timer_run = 1'b1;
          end
        end
      endcase
    end
  end

  // MSB/tag capture and saturating pair timer
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      msb_q   <= '0;
      tag_q   <= '0;
      timer_q <= '0;
    end else begin
      if (capture_msb) begin
        msb_q   <= bus.INA220_DATA;
        tag_q   <= bus.REG_TAG;
        timer_q <= '0;
      end else if (timer_run && (timer_q != '1)) begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

  // Stage the completed word for the FIFO push in the following cycle
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      push_q      <= 1'b0;
      push_word_q <= '0;
      push_tag_q  <= '0;
    end else begin
      push_q <= emit_word;
      if (emit_word) begin
        push_word_q <= {msb_q, bus.INA220_DATA};
        push_tag_q  <= tag_q;
      end
    end
  end

  assign fifo_full  = (level_q == DEPTH_LVL);
  assign do_pop     = (level_q != '0) & bus.RESULT_READY;
  assign do_push    = push_q & (~fifo_full | do_pop);
  assign drop_word  = push_q & fifo_full & ~do_pop;
  assign rd_ptr_inc = rd_ptr_q + AW'(1);

  // Occupancy and the registered head word seen on RESULT/RESULT_TAG
  always_comb begin
    level_d     = level_q;
    head_word_d = head_word_q;
    head_tag_d  = head_tag_q;
    if (do_push && !do_pop)      level_d = level_q + 5'd1;
    else if (!do_push && do_pop) level_d = level_q - 5'd1;

    // The head register is preloaded with whichever entry becomes head next
    // cycle, so it tracks the FIFO without an extra read stage.
    if (level_d == '0) begin
      head_word_d = '0;
      head_tag_d  = '0;
    end else if (do_pop) begin
      if (level_q == 5'd1) begin
        head_word_d = push_word_q;
        head_tag_d  = push_tag_q;
      end else begin
        head_word_d = mem[rd_ptr_inc][15:0];
        head_tag_d  = mem[rd_ptr_inc][18:16];
      end
    end else if ((level_q == '0) && do_push) begin
      head_word_d = push_word_q;
      head_tag_d  = push_tag_q;
    end
  end

  // FIFO storage; contents need no reset since the head register gates them
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr_q] <= {push_tag_q, push_word_q};
  end

  // FIFO pointers, level and head register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      head_word_q <= '0;
      head_tag_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_inc;
      level_q     <= level_d;
      head_word_q <= head_word_d;
      head_tag_q  <= head_tag_d;
    end
  end

  // Sticky error flags; a new error beats a coincident clear
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      err_tmo_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_tmo_q <= timeout_hit | (err_tmo_q & ~bus.ERR_CLR);
      err_ovf_q <= drop_word   | (err_ovf_q & ~bus.ERR_CLR);
    end
  end

  assign bus.RESULT       = head_word_q;
  assign bus.RESULT_TAG   = head_tag_q;
  assign bus.RESULT_VALID = (level_q != '0);
  assign bus.LEVEL        = level_q;
  assign bus.ERR_TIMEOUT  = err_tmo_q;
  assign bus.ERR_OVF      = err_ovf_q;

endmodule

// File: tb/tb_ina220_word_assembler.sv
// Self-checking bench for ina220_word_assembler: table-driven pairs plus
// hand-written sequences, with every accepted word checked against a queue.
`timescale 1ns/1ps
module tb_ina220_word_assembler;

  logic PCLK = 1'b0;
  logic PRESETN = 1'b0;
  always #5 PCLK = ~PCLK;

  ina220_word_assembler_if bus();

  ina220_word_assembler #(
    .DEPTH(4),
    .TIMEOUT_CYCLES(16'd20)
  ) dut (
    .PCLK(PCLK),
    .PRESETN(PRESETN),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  logic [18:0] exp_q[$];

  typedef struct {
    logic [2:0]  tag;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    int          low;
    logic [15:0] exp_word;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b, input int low);
    bus.INA220_DATA = b;
    bus.WE = 1'b0;
    tick(low);
    bus.WE = 1'b1;
    tick(1);
  endtask

  task automatic send_pair(input logic [2:0] tag, input logic [7:0] m, input logic [7:0] l,
                           input logic [15:0] exp_word, input bit expect_push, input int low);
    bus.REG_TAG = tag;
    strobe(m, low);
    if (expect_push) exp_q.push_back({tag, exp_word});
    strobe(l, low);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || (bus.LEVEL != 5'd0)) && (n < 100)) begin
      tick(1);
      n++;
    end
    chk(name, {27'd0, bus.LEVEL}, 32'd0);
    chk({name, "_pending"}, exp_q.size(), 32'd0);
  endtask

  // Scoreboard: every accepted head word must match the oldest expectation
  initial begin : monitor
    logic [18:0] e;
    forever begin
      @(negedge PCLK);
      if (PRESETN && bus.RESULT_VALID) begin
        valid_cycles++;
        if (bus.RESULT_READY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%0h required=none", {bus.RESULT_TAG, bus.RESULT});
          end else begin
            e = exp_q.pop_front();
            chk("pop_word", {13'd0, bus.RESULT_TAG, bus.RESULT}, {13'd0, e});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int vc;
    bus.WE = 1'b1;
    bus.INA220_DATA = 8'h00;
    bus.REG_TAG = 3'd0;
    bus.FRAME_CLR = 1'b0;
    bus.RESULT_READY = 1'b0;
    bus.ERR_CLR = 1'b0;

    vecs[0] = '{tag: 3'd5, msb: 8'hAB, lsb: 8'hCD, low: 5, exp_word: 16'hABCD};
    vecs[1] = '{tag: 3'd0, msb: 8'h00, lsb: 8'h00, low: 1, exp_word: 16'h0000};
    vecs[2] = '{tag: 3'd7, msb: 8'hFF, lsb: 8'hFF, low: 1, exp_word: 16'hFFFF};
    vecs[3] = '{tag: 3'd1, msb: 8'hA5, lsb: 8'h5A, low: 2, exp_word: 16'hA55A};
    vecs[4] = '{tag: 3'd4, msb: 8'h80, lsb: 8'h01, low: 3, exp_word: 16'h8001};

    // Reset state
    tick(3);
    chk("rst_result", {16'd0, bus.RESULT}, 32'd0);
    chk("rst_misc", {24'd0, bus.RESULT_TAG, bus.RESULT_VALID, bus.ERR_TIMEOUT, bus.ERR_OVF},
        32'd0);
    chk("rst_level", {27'd0, bus.LEVEL}, 32'd0);
    PRESETN = 1'b1;
    tick(2);

    // Basic pair with exact latency and single-cycle valid
    bus.RESULT_READY = 1'b1;
    bus.REG_TAG = 3'd2;
    strobe(8'h12, 1);
    exp_q.push_back({3'd2, 16'h1234});
    vc = valid_cycles;
    bus.INA220_DATA = 8'h34;
    bus.WE = 1'b0;
    tick(1);
    chk("basic_valid_early", {31'd0, bus.RESULT_VALID}, 32'd0);
    bus.WE = 1'b1;
    tick(1);
    chk("basic_valid", {31'd0, bus.RESULT_VALID}, 32'd1);
    chk("basic_result", {16'd0, bus.RESULT}, 32'h1234);
    chk("basic_tag", {29'd0, bus.RESULT_TAG}, 32'd2);
    chk("basic_level", {27'd0, bus.LEVEL}, 32'd1);
    tick(1);
    chk("basic_level_after", {27'd0, bus.LEVEL}, 32'd0);
    chk("basic_valid_width", valid_cycles - vc, 32'd1);

    // Table-driven pairs (vector 0 is the long-strobe case)
    for (int i = 0; i < 5; i++) begin
      send_pair(vecs[i].tag, vecs[i].msb, vecs[i].lsb, vecs[i].exp_word, 1'b1, vecs[i].low);
      wait_drain($sformatf("vec%0d_drain", i));
    end

    // Timeout discards the partial word
    bus.REG_TAG = 3'd6;
    strobe(8'h55, 1);
    tick(25);
    chk("tmo_flag", {31'd0, bus.ERR_TIMEOUT}, 32'd1);
    chk("tmo_level", {27'd0, bus.LEVEL}, 32'd0);
    bus.ERR_CLR = 1'b1;
    tick(1);
    bus.ERR_CLR = 1'b0;
    chk("tmo_clr", {31'd0, bus.ERR_TIMEOUT}, 32'd0);
    send_pair(3'd3, 8'h01, 8'h02, 16'h0102, 1'b1, 1);
    wait_drain("tmo_next_pair");

    // LSB on the terminal-count cycle still completes the word
    bus.REG_TAG = 3'd3;
    strobe(8'h9A, 1);
    exp_q.push_back({3'd3, 16'h9ABC});
    tick(18);
    strobe(8'hBC, 1);
    wait_drain("tmo_edge_drain");
    chk("tmo_edge_flag", {31'd0, bus.ERR_TIMEOUT}, 32'd0);

    // Overflow: fifth word dropped, first four drain in order
    bus.RESULT_READY = 1'b0;
    for (int i = 1; i <= 5; i++)
      send_pair(3'd0, 8'h00, 8'(i), 16'(i), (i <= 4), 1);
    tick(3);
    chk("ovf_level", {27'd0, bus.LEVEL}, 32'd4);
    chk("ovf_flag", {31'd0, bus.ERR_OVF}, 32'd1);
    chk("ovf_head", {16'd0, bus.RESULT}, 32'h0001);
    bus.ERR_CLR = 1'b1;
    tick(1);
    bus.ERR_CLR = 1'b0;
    chk("ovf_clr", {31'd0, bus.ERR_OVF}, 32'd0);
    bus.RESULT_READY = 1'b1;
    wait_drain("ovf_drain");

    // Full FIFO with a pop in the push cycle; order kept across wrap
    bus.RESULT_READY = 1'b0;
    for (int i = 1; i <= 4; i++)
      send_pair(3'd5, 8'hC0, 8'(i), {8'hC0, 8'(i)}, 1'b1, 1);
    bus.REG_TAG = 3'd5;
    strobe(8'hC0, 1);
    exp_q.push_back({3'd5, 16'hC005});
    bus.INA220_DATA = 8'h05;
    bus.WE = 1'b0;
    tick(1);
    bus.WE = 1'b1;
    bus.RESULT_READY = 1'b1;
    tick(1);
    bus.RESULT_READY = 1'b0;
    chk("fullpop_level", {27'd0, bus.LEVEL}, 32'd4);
    chk("fullpop_ovf", {31'd0, bus.ERR_OVF}, 32'd0);
    bus.RESULT_READY = 1'b1;
    wait_drain("fullpop_drain");

    // FRAME_CLR alone mid-pair
    bus.REG_TAG = 3'd1;
    strobe(8'hEE, 1);
    bus.FRAME_CLR = 1'b1;
    tick(1);
    bus.FRAME_CLR = 1'b0;
    send_pair(3'd1, 8'h10, 8'h20, 16'h1020, 1'b1, 1);
    wait_drain("fclr_drain");

    // FRAME_CLR coincident with a byte event: the byte is ignored
    strobe(8'hFF, 1);
    bus.INA220_DATA = 8'h77;
    bus.WE = 1'b0;
    bus.FRAME_CLR = 1'b1;
    tick(1);
    bus.FRAME_CLR = 1'b0;
    bus.WE = 1'b1;
    tick(3);
    chk("fclr_coinc_level", {27'd0, bus.LEVEL}, 32'd0);
    chk("fclr_coinc_err", {30'd0, bus.ERR_TIMEOUT, bus.ERR_OVF}, 32'd0);
    send_pair(3'd1, 8'h10, 8'h20, 16'h1020, 1'b1, 1);
    wait_drain("fclr_coinc_drain");

    // Reset mid-pair with a word buffered
    bus.RESULT_READY = 1'b0;
    send_pair(3'd2, 8'hAA, 8'hBB, 16'hAABB, 1'b0, 1);
    tick(2);
    chk("prerst_level", {27'd0, bus.LEVEL}, 32'd1);
    bus.REG_TAG = 3'd2;
    strobe(8'h99, 1);
    PRESETN = 1'b0;
    tick(1);
    chk("midrst_result", {16'd0, bus.RESULT}, 32'd0);
    chk("midrst_misc", {19'd0, bus.LEVEL, bus.RESULT_TAG, bus.RESULT_VALID, bus.ERR_TIMEOUT,
        bus.ERR_OVF}, 32'd0);
    tick(2);
    PRESETN = 1'b1;
    tick(2);
    bus.RESULT_READY = 1'b1;
    send_pair(3'd4, 8'h33, 8'h44, 16'h3344, 1'b1, 1);
    wait_drain("postrst_drain");
    chk("final_err", {30'd0, bus.ERR_TIMEOUT, bus.ERR_OVF}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
